// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller.
// State, forward-select and register-zero constants plus the forward helper.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_LU    = 2'b01,
        ST_MWAIT = 2'b10
    } state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // The youngest producer (EX/MEM) wins over MEM/WB.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        if (mem_we && mem_rd != REG_ZERO && mem_rd == src)
            return FWD_MEM;
        else if (wb_we && wb_rd != REG_ZERO && wb_rd == src)
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Clear has priority over a same-cycle increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_clr)
            r_cnt <= '0;
        else if (i_inc && r_cnt != {CNT_W{1'b1}})
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-wait freeze, branch/jump flush,
// load-use bubble, operand forwarding and stall/flush statistics.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic [4:0]       EX_rs,
    input  logic [4:0]       EX_rt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_RegDest,
    input  logic             EX_BranchTaken,
    input  logic             ID_Jump,
    input  logic             MEM_RegWrite,
    input  logic [4:0]       MEM_RegDest,
    input  logic             MEM_MemRead,
    input  logic             MEM_MemWrite,
    input  logic             WB_RegWrite,
    input  logic [4:0]       WB_RegDest,
    input  logic             mem_ready,
    input  logic             cnt_clr,
    output logic             PC_stall,
    output logic             IFID_stall,
    output logic             IDEX_stall,
    output logic             EXMEM_stall,
    output logic             IFID_flush,
    output logic             IDEX_flush,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state
);

    localparam logic [16:0] TO_LIM = 17'(TIMEOUT);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_wait;
    logic        r_timeout;
    logic        w_mem_wait;
    logic        w_load_use;
    logic        w_flush_any;
    logic        w_cnt_clr;
    logic [16:0] w_wait_inc;

    assign w_mem_wait = (MEM_MemRead | MEM_MemWrite) & ~mem_ready;

    // A load-use bubble is only inserted once; LU never re-triggers.
    assign w_load_use = EX_MemRead
                      && EX_RegDest != REG_ZERO
                      && (EX_RegDest == ID_rs || EX_RegDest == ID_rt)
                      && r_state != ST_LU;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= ST_RUN;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = ST_RUN;
        if (w_mem_wait)
            w_next = ST_MWAIT;
        else if (EX_BranchTaken)
            w_next = ST_RUN;
        else if (w_load_use)
            w_next = ST_LU;
    end

    always_comb begin
        PC_stall    = 1'b0;
        IFID_stall  = 1'b0;
        IDEX_stall  = 1'b0;
        EXMEM_stall = 1'b0;
        IFID_flush  = 1'b0;
        IDEX_flush  = 1'b0;
        ForwardA    = FWD_REG;
        ForwardB    = FWD_REG;
        if (!reset) begin
            ForwardA = fwd_sel(EX_rs, MEM_RegWrite, MEM_RegDest,
                               WB_RegWrite, WB_RegDest);
            ForwardB = fwd_sel(EX_rt, MEM_RegWrite, MEM_RegDest,
                               WB_RegWrite, WB_RegDest);
            if (w_mem_wait) begin
                PC_stall    = 1'b1;
                IFID_stall  = 1'b1;
                IDEX_stall  = 1'b1;
                EXMEM_stall = 1'b1;
            end else if (EX_BranchTaken) begin
                IFID_flush = 1'b1;
                IDEX_flush = 1'b1;
            end else if (w_load_use) begin
                PC_stall   = 1'b1;
                IFID_stall = 1'b1;
                IDEX_flush = 1'b1;
            end else if (ID_Jump) begin
                IFID_flush = 1'b1;
            end
        end
    end

    assign w_wait_inc = {1'b0, r_wait} + 17'd1;

    // Consecutive-wait watchdog; the error stays until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wait    <= '0;
            r_timeout <= 1'b0;
        end else if (w_mem_wait) begin
            if (w_wait_inc <= TO_LIM)
                r_wait <= w_wait_inc[15:0];
            if (w_wait_inc >= TO_LIM)
                r_timeout <= 1'b1;
        end else begin
            r_wait <= '0;
        end
    end

    assign w_flush_any = IFID_flush | IDEX_flush;
    assign w_cnt_clr   = cnt_clr | reset;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .i_inc (PC_stall),
        .i_clr (w_cnt_clr),
        .o_cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .i_inc (w_flush_any),
        .i_clr (w_cnt_clr),
        .o_cnt (flush_cnt)
    );

    assign mem_timeout = r_timeout;
    assign state       = r_state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model.
module tb_hazard_ctrl;

    localparam int TO   = 4;
    localparam int CW   = 4;
    localparam int CMAX = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic [4:0]    ID_rs, ID_rt, EX_rs, EX_rt, EX_RegDest;
    logic [4:0]    MEM_RegDest, WB_RegDest;
    logic          EX_MemRead, EX_BranchTaken, ID_Jump;
    logic          MEM_RegWrite, MEM_MemRead, MEM_MemWrite;
    logic          WB_RegWrite, mem_ready, cnt_clr;
    logic          PC_stall, IFID_stall, IDEX_stall, EXMEM_stall;
    logic          IFID_flush, IDEX_flush, mem_timeout;
    logic [1:0]    ForwardA, ForwardB, state;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    int m_state = 0;
    int m_wait  = 0;
    int m_to    = 0;
    int m_sc    = 0;
    int m_fc    = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .ID_rs(ID_rs), .ID_rt(ID_rt),
        .EX_rs(EX_rs), .EX_rt(EX_rt),
        .EX_MemRead(EX_MemRead), .EX_RegDest(EX_RegDest),
        .EX_BranchTaken(EX_BranchTaken), .ID_Jump(ID_Jump),
        .MEM_RegWrite(MEM_RegWrite), .MEM_RegDest(MEM_RegDest),
        .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
        .WB_RegWrite(WB_RegWrite), .WB_RegDest(WB_RegDest),
        .mem_ready(mem_ready), .cnt_clr(cnt_clr),
        .PC_stall(PC_stall), .IFID_stall(IFID_stall),
        .IDEX_stall(IDEX_stall), .EXMEM_stall(EXMEM_stall),
        .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
        .ForwardA(ForwardA), .ForwardB(ForwardB),
        .mem_timeout(mem_timeout), .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h @%0t",
                     tag, got, exp, $time);
        end
    endtask

    function automatic int fwd(input logic [4:0] src);
        if (MEM_RegWrite && MEM_RegDest != 0 && MEM_RegDest == src)
            return 1;
        if (WB_RegWrite && WB_RegDest != 0 && WB_RegDest == src)
            return 2;
        return 0;
    endfunction

    task automatic idle();
        ID_rs = 0; ID_rt = 0; EX_rs = 0; EX_rt = 0;
        EX_MemRead = 0; EX_RegDest = 0;
        EX_BranchTaken = 0; ID_Jump = 0;
        MEM_RegWrite = 0; MEM_RegDest = 0;
        MEM_MemRead = 0; MEM_MemWrite = 0;
        WB_RegWrite = 0; WB_RegDest = 0;
        mem_ready = 1; cnt_clr = 0; reset = 0;
    endtask

    // Called at the negedge: check against the model, then advance it
    // and move to just after the next posedge.
    task automatic eval();
        int wait_c, lu, stl, fl, ifl, idl, fa, fb, nst;
        stl = 0; ifl = 0; idl = 0; fa = 0; fb = 0; lu = 0; nst = 0;
        wait_c = ((MEM_MemRead || MEM_MemWrite) && !mem_ready) ? 1 : 0;
        if (!reset) begin
            lu = (EX_MemRead && EX_RegDest != 0 && m_state != 1 &&
                  (EX_RegDest == ID_rs || EX_RegDest == ID_rt)) ? 1 : 0;
            fa = fwd(EX_rs);
            fb = fwd(EX_rt);
            if (wait_c == 1) begin
                stl = 4'b1111; nst = 2;
            end else if (EX_BranchTaken) begin
                ifl = 1; idl = 1;
            end else if (lu == 1) begin
                stl = 4'b1100; idl = 1; nst = 1;
            end else if (ID_Jump) begin
                ifl = 1;
            end
        end
        chk("stalls", {PC_stall, IFID_stall, IDEX_stall, EXMEM_stall},
            stl);
        chk("flush", {IFID_flush, IDEX_flush}, {ifl[0], idl[0]});
        chk("fwdA", ForwardA, fa);
        chk("fwdB", ForwardB, fb);
        chk("state", state, m_state);
        chk("timeout", mem_timeout, m_to);
        chk("stall_cnt", stall_cnt, m_sc);
        chk("flush_cnt", flush_cnt, m_fc);
        if (reset) begin
            m_state = 0; m_wait = 0; m_to = 0; m_sc = 0; m_fc = 0;
        end else begin
            m_state = nst;
            m_wait = wait_c ? m_wait + 1 : 0;
            if (m_wait >= TO) m_to = 1;
            if (cnt_clr) begin
                m_sc = 0; m_fc = 0;
            end else begin
                if (stl[3] && m_sc < CMAX) m_sc++;
                if ((ifl || idl) && m_fc < CMAX) m_fc++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        #4;
        eval();
    endtask

    task automatic clear_cnt();
        idle(); cnt_clr = 1; step(); cnt_clr = 0;
    endtask

    initial begin
        idle();
        reset = 1;
        @(posedge clk); #1;
        #4;
        chk("rst_stall", PC_stall, 0);
        eval();
        chk("rst_state", state, 0);
        chk("rst_scnt", stall_cnt, 0);
        idle();

        // load-use bubble
        EX_MemRead = 1; EX_RegDest = 5; ID_rs = 5;
        step();
        chk("lu_state", state, 1);
        chk("lu_scnt", stall_cnt, 1);
        #4;
        chk("lu_nodbl", PC_stall, 0);
        eval();
        chk("lu_back", state, 0);
        chk("lu_scnt2", stall_cnt, 1);

        // three-cycle memory wait
        clear_cnt();
        MEM_MemRead = 1; mem_ready = 0;
        repeat (3) step();
        chk("mw_state", state, 2);
        mem_ready = 1;
        #4;
        chk("mw_free", EXMEM_stall, 0);
        eval();
        chk("mw_back", state, 0);
        chk("mw_scnt", stall_cnt, 3);
        chk("mw_nofl", flush_cnt, 0);

        // watchdog
        idle(); MEM_MemWrite = 1; mem_ready = 0;
        repeat (3) step();
        chk("to_early", mem_timeout, 0);
        step();
        chk("to_set", mem_timeout, 1);
        repeat (2) step();
        mem_ready = 1;
        repeat (3) step();
        chk("to_hold", mem_timeout, 1);
        idle(); reset = 1; step();
        chk("to_clr", mem_timeout, 0);

        // branch beats load-use
        idle();
        EX_BranchTaken = 1; EX_MemRead = 1; EX_RegDest = 3; ID_rt = 3;
        ID_Jump = 1;
        #4;
        chk("br_pc", PC_stall, 0);
        chk("br_fl", {IFID_flush, IDEX_flush}, 2'b11);
        eval();
        chk("br_fcnt", flush_cnt, 1);
        chk("br_state", state, 0);

        // forwarding priority
        idle();
        MEM_RegWrite = 1; WB_RegWrite = 1;
        MEM_RegDest = 7; WB_RegDest = 7; EX_rs = 7; EX_rt = 0;
        #4;
        chk("fw_a_mem", ForwardA, 2'b01);
        chk("fw_b_reg", ForwardB, 2'b00);
        eval();
        MEM_RegWrite = 0;
        #4;
        chk("fw_a_wb", ForwardA, 2'b10);
        eval();

        // reset in the middle of a wait
        idle(); MEM_MemRead = 1; mem_ready = 0;
        repeat (2) step();
        reset = 1;
        #4;
        chk("rw_stall", {PC_stall, IFID_stall, IDEX_stall, EXMEM_stall},
            0);
        eval();
        chk("rw_state", state, 0);
        chk("rw_scnt", stall_cnt, 0);

        // counter saturation and clear priority
        idle(); MEM_MemRead = 1; mem_ready = 0;
        repeat (18) step();
        chk("sat_scnt", stall_cnt, CMAX);
        cnt_clr = 1; step();
        chk("clr_win", stall_cnt, 0);
        chk("clr_to", mem_timeout, 1);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            ID_rs = 5'($urandom_range(0, 3));
            ID_rt = 5'($urandom_range(0, 3));
            EX_rs = 5'($urandom_range(0, 3));
            EX_rt = 5'($urandom_range(0, 3));
            EX_RegDest  = 5'($urandom_range(0, 3));
            MEM_RegDest = 5'($urandom_range(0, 3));
            WB_RegDest  = 5'($urandom_range(0, 3));
            EX_MemRead     = ($urandom_range(0, 2) == 0);
            EX_BranchTaken = ($urandom_range(0, 7) == 0);
            ID_Jump        = ($urandom_range(0, 5) == 0);
            MEM_RegWrite   = ($urandom_range(0, 1) == 0);
            WB_RegWrite    = ($urandom_range(0, 1) == 0);
            MEM_MemRead    = ($urandom_range(0, 3) == 0);
            MEM_MemWrite   = ($urandom_range(0, 5) == 0);
            mem_ready      = ($urandom_range(0, 3) != 0);
            cnt_clr        = ($urandom_range(0, 29) == 0);
            reset          = ($urandom_range(0, 59) == 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
